// File: rtl/a2d_spi_resp_if.sv
// SPI link between the A2D master and the responder model.
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit serial A2D.
// Each frame returns the conversion for the channel commanded in the
// previous accepted frame. Optional frame-length checking is enabled by
// defining A2D_RESP_FRAME_ERR_EN; without it frm_err is tied low.
module a2d_spi_resp #(
  parameter int FRAME_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  a2d_spi_resp_if.slave        spi,
  input  logic [95:0]          chan_data,
  output logic                 cmd_vld,
  output logic [2:0]           cmd_ch,
  output logic                 frm_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // [0] first sync stage, [1] synced copy, [2] previous synced value
  logic [2:0]  ss_q, ss_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [1:0]  mosi_q, mosi_d;

  state_t      state_q, state_d;
  logic [15:0] tx_q, tx_d;
  // only command bits [13:11] are ever used, so the upper bits are not kept
  logic [13:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  ch_q, ch_d;
  logic [2:0]  cmd_ch_q, cmd_ch_d;
  logic        cmd_vld_q, cmd_vld_d;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, frame_ok;
  logic [11:0] chan_sel;

  // synchronizer shift paths and edge detection
  always_comb begin
    ss_d      = {ss_q[1:0], spi.SS_n};
    sclk_d    = {sclk_q[1:0], spi.SCLK};
    mosi_d    = {mosi_q[0], spi.MOSI};
    ss_fall   = ss_q[2] & ~ss_q[1];
    ss_rise   = ~ss_q[2] & ss_q[1];
    sclk_fall = sclk_q[2] & ~sclk_q[1];
    sclk_rise = ~sclk_q[2] & sclk_q[1];
    frame_ok  = (cnt_q == 5'(FRAME_BITS));
  end

  // channel mux for the value returned in the next frame
  always_comb begin
    chan_sel = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (ch_q == 3'(k)) chan_sel = chan_data[12*k +: 12];
    end
  end

  // frame state machine: SS_n rise takes priority over any SCLK edge
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    cmd_ch_d  = cmd_ch_q;
    cmd_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          tx_d    = {4'b0000, chan_sel};
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (frame_ok) begin
            ch_d      = rx_q[13:11];
            cmd_ch_d  = rx_q[13:11];
            cmd_vld_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_d = {rx_q[12:0], mosi_q[1]};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end else if (sclk_fall && (cnt_q != 5'd0)) begin
          tx_d = {tx_q[14:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q      <= '1;
      sclk_q    <= '1;
      mosi_q    <= '0;
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      ch_q      <= '0;
      cmd_ch_q  <= '0;
      cmd_vld_q <= 1'b0;
    end else begin
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      cmd_ch_q  <= cmd_ch_d;
      cmd_vld_q <= cmd_vld_d;
    end
  end

  assign spi.MISO = (state_q == ACTIVE) ? tx_q[15] : 1'b1;
  assign cmd_vld  = cmd_vld_q;
  assign cmd_ch   = cmd_ch_q;

`ifdef A2D_RESP_FRAME_ERR_EN
  logic frm_err_q, frm_err_d;

  // sticky flag for any frame closed with the wrong bit count
  always_comb begin
    frm_err_d = frm_err_q;
    if ((state_q == ACTIVE) && ss_rise && !frame_ok) frm_err_d = 1'b1;
  end

  // frame error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frm_err_q <= 1'b0;
    else     frm_err_q <= frm_err_d;
  end

  assign frm_err = frm_err_q;

`ifndef SYNTHESIS
  // report bad frame lengths in simulation
  always @(posedge clk) begin
    if (!rst && (state_q == ACTIVE) && ss_rise && !frame_ok)
      $error("a2d_spi_resp: frame closed after %0d bits", cnt_q);
  end
`endif
`else
  assign frm_err = 1'b0;
`endif

endmodule
